// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the XMakina branch sequencer: states, condition codes,
// instruction field positions and the condition evaluator.
package branch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_LINK   = 2'd2,
        ST_COMMIT = 2'd3
    } seq_state_t;

    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_NE = 3'b001;
    localparam logic [2:0] COND_CS = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_N  = 3'b100;
    localparam logic [2:0] COND_GE = 3'b101;
    localparam logic [2:0] COND_LT = 3'b110;
    localparam logic [2:0] COND_AL = 3'b111;

    localparam int unsigned TYPE_BIT = 13;
    localparam int unsigned COND_HI  = 12;
    localparam int unsigned COND_LO  = 10;
    localparam int unsigned BL_H     = 12;
    localparam int unsigned COND_H   = 9;

    function automatic logic cond_met(input logic [2:0] cond,
                                      input logic z, input logic n,
                                      input logic c, input logic v);
        logic met;
        met = 1'b0;
        case (cond)
            COND_EQ: met = z;
            COND_NE: met = !z;
            COND_CS: met = c;
            COND_CC: met = !c;
            COND_N:  met = n;
            COND_GE: met = (n == v);
            COND_LT: met = (n != v);
            COND_AL: met = 1'b1;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/branch_sequencer_decoder.sv
// Branch offset decoder: sign-extends the BL (13-bit) or conditional (10-bit)
// offset field depending on the instruction type bit.
module branch_decoder
    import branch_sequencer_pkg::*;
#(
    parameter int unsigned WORD = 16
) (
    input  logic [TYPE_BIT:0] inst_i,
    output logic [WORD-1:0]   offset_o
);

    always_comb begin
        offset_o = '0;
        if (inst_i[TYPE_BIT]) begin
            offset_o = {{(WORD-COND_H-1){inst_i[COND_H]}}, inst_i[COND_H:0]};
        end else begin
            offset_o = {{(WORD-BL_H-1){inst_i[BL_H]}}, inst_i[BL_H:0]};
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle executor for XMakina BL and conditional branches: latch, evaluate,
// optionally write the link register, then commit the new PC.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int unsigned WORD   = 16,
    parameter int unsigned LR_IDX = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [WORD-1:0] instWord_i,
    input  logic [WORD-1:0] pc_i,
    input  logic            pswZ_i,
    input  logic            pswN_i,
    input  logic            pswC_i,
    input  logic            pswV_i,
    output logic            busy_o,
    output logic            rfWrReq_o,
    input  logic            rfWrGnt_i,
    output logic [2:0]      rfWrIdx_o,
    output logic [WORD-1:0] rfWrData_o,
    output logic            pcWrEn_o,
    output logic [WORD-1:0] pcNext_o,
    output logic            done_o,
    output logic            taken_o,
    output logic            illegal_o
);

    seq_state_t      state_q, state_d;
    logic [WORD-1:0] inst_q, inst_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] pc_next_q, pc_next_d;
    logic [3:0]      flags_q, flags_d;   // {Z, N, C, V}
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    logic [WORD-1:0] offset;
    logic [WORD-1:0] target;

    branch_decoder #(.WORD(WORD)) u_decoder (
        .inst_i   (inst_q[TYPE_BIT:0]),
        .offset_o (offset)
    );

    assign target = pc_q + {offset[WORD-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        flags_d   = flags_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    inst_d    = instWord_i;
                    pc_d      = pc_i;
                    flags_d   = {pswZ_i, pswN_i, pswC_i, pswV_i};
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                pc_next_d = target;
                if (inst_q[WORD-1:TYPE_BIT+1] != '0) begin
                    illegal_d = 1'b1;
                    taken_d   = 1'b0;
                    state_d   = ST_COMMIT;
                end else if (!inst_q[TYPE_BIT]) begin
                    state_d = ST_LINK;
                end else begin
                    taken_d = cond_met(inst_q[COND_HI:COND_LO], flags_q[3],
                                       flags_q[2], flags_q[1], flags_q[0]);
                    state_d = ST_COMMIT;
                end
            end
            ST_LINK: begin
                if (rfWrGnt_i) begin
                    taken_d = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            inst_q    <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
            flags_q   <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            flags_q   <= flags_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    // Result flags are only meaningful alongside done_o, so gate them by COMMIT.
    assign busy_o     = (state_q != ST_IDLE);
    assign rfWrReq_o  = (state_q == ST_LINK);
    assign rfWrIdx_o  = 3'(LR_IDX);
    assign rfWrData_o = pc_q;
    assign pcNext_o   = pc_next_q;
    assign done_o     = (state_q == ST_COMMIT);
    assign pcWrEn_o   = (state_q == ST_COMMIT) && taken_q;
    assign taken_o    = (state_q == ST_COMMIT) && taken_q;
    assign illegal_o  = (state_q == ST_COMMIT) && illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// branches compared against an arithmetic reference model.
module tb_branch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] instWord_i;
    logic [15:0] pc_i;
    logic        pswZ_i, pswN_i, pswC_i, pswV_i;
    logic        busy_o;
    logic        rfWrReq_o;
    logic        rfWrGnt_i;
    logic [2:0]  rfWrIdx_o;
    logic [15:0] rfWrData_o;
    logic        pcWrEn_o;
    logic [15:0] pcNext_o;
    logic        done_o;
    logic        taken_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    branch_sequencer #(.WORD(16), .LR_IDX(5)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .instWord_i (instWord_i),
        .pc_i       (pc_i),
        .pswZ_i     (pswZ_i),
        .pswN_i     (pswN_i),
        .pswC_i     (pswC_i),
        .pswV_i     (pswV_i),
        .busy_o     (busy_o),
        .rfWrReq_o  (rfWrReq_o),
        .rfWrGnt_i  (rfWrGnt_i),
        .rfWrIdx_o  (rfWrIdx_o),
        .rfWrData_o (rfWrData_o),
        .pcWrEn_o   (pcWrEn_o),
        .pcNext_o   (pcNext_o),
        .done_o     (done_o),
        .taken_o    (taken_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: decode the instruction with integer arithmetic.
    function automatic void model(input logic [15:0] w, input logic [15:0] p,
                                  input logic z, input logic n,
                                  input logic c, input logic v,
                                  output logic e_taken, output logic e_ill,
                                  output logic e_bl, output logic [15:0] e_tgt);
        int off;
        int t;
        logic cr;
        if (w[13]) begin
            off = int'(w[9:0]);
            if (off >= 512) off = off - 1024;
        end else begin
            off = int'(w[12:0]);
            if (off >= 4096) off = off - 8192;
        end
        t = int'(p) + 2 * off;
        e_tgt = t[15:0];
        case (w[12:10])
            3'd0: cr = z;
            3'd1: cr = !z;
            3'd2: cr = c;
            3'd3: cr = !c;
            3'd4: cr = n;
            3'd5: cr = (n == v);
            3'd6: cr = (n != v);
            default: cr = 1'b1;
        endcase
        e_ill   = (w[15:14] != 2'b00);
        e_bl    = !e_ill && (w[13] == 1'b0);
        e_taken = e_ill ? 1'b0 : (e_bl ? 1'b1 : cr);
    endfunction

    task automatic run_op(input string name, input logic [15:0] w, input logic [15:0] p,
                          input logic z, input logic n, input logic c, input logic v,
                          input int stall);
        logic e_taken, e_ill, e_bl;
        logic [15:0] e_tgt;
        int done_at = -1;
        int req_cycles = 0;
        int pcwr_cnt = 0;
        int stalls = stall;
        int exp_lat;
        logic data_ok = 1'b1;
        logic busy_ok = 1'b1;
        logic got_taken = 1'b0, got_ill = 1'b0, got_pcwr = 1'b0;
        logic [15:0] got_tgt = '0;

        model(w, p, z, n, c, v, e_taken, e_ill, e_bl, e_tgt);
        exp_lat = e_bl ? 3 + stall : 2;

        @(negedge clk_i);
        start_i = 1'b1; instWord_i = w; pc_i = p;
        pswZ_i = z; pswN_i = n; pswC_i = c; pswV_i = v;
        @(negedge clk_i);
        // Scramble inputs after acceptance; only the latched copies may matter.
        start_i = 1'b0; instWord_i = 16'($urandom); pc_i = 16'($urandom);
        pswZ_i = 1'($urandom); pswN_i = 1'($urandom);
        pswC_i = 1'($urandom); pswV_i = 1'($urandom);

        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            if (k > 1) @(negedge clk_i);
            if (!busy_o) busy_ok = 1'b0;
            if (pcWrEn_o) pcwr_cnt++;
            if (rfWrReq_o) begin
                req_cycles++;
                if (rfWrData_o !== p || rfWrIdx_o !== 3'd5) data_ok = 1'b0;
                if (stalls > 0) begin
                    rfWrGnt_i = 1'b0;
                    stalls--;
                end else begin
                    rfWrGnt_i = 1'b1;
                end
            end else begin
                rfWrGnt_i = 1'($urandom);
            end
            if (done_o) begin
                done_at   = k;
                got_taken = taken_o;
                got_ill   = illegal_o;
                got_pcwr  = pcWrEn_o;
                got_tgt   = pcNext_o;
            end
        end
        @(negedge clk_i);
        rfWrGnt_i = 1'b0;

        checks++;
        if (done_at !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, done_at, exp_lat);
        end
        checks++;
        if (got_taken !== e_taken || got_ill !== e_ill) begin
            errors++;
            $display("FAIL %s taken/illegal: got %b/%b expected %b/%b",
                     name, got_taken, got_ill, e_taken, e_ill);
        end
        checks++;
        if (got_tgt !== e_tgt) begin
            errors++;
            $display("FAIL %s pcNext: got %h expected %h", name, got_tgt, e_tgt);
        end
        checks++;
        if (got_pcwr !== e_taken || pcwr_cnt != (e_taken ? 1 : 0)) begin
            errors++;
            $display("FAIL %s pcWrEn: at_done %b count %0d expected %b", name,
                     got_pcwr, pcwr_cnt, e_taken);
        end
        checks++;
        if (req_cycles != (e_bl ? stall + 1 : 0) || !data_ok) begin
            errors++;
            $display("FAIL %s link write: req_cycles %0d data_ok %b expected %0d",
                     name, req_cycles, data_ok, e_bl ? stall + 1 : 0);
        end
        checks++;
        if (!busy_ok || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s busy/idle: busy_ok %b busy_after %b done_after %b expected 1 0 0",
                     name, busy_ok, busy_o, done_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({busy_o, rfWrReq_o, pcWrEn_o, done_o, taken_o, illegal_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy_o, rfWrReq_o, pcWrEn_o, done_o, taken_o, illegal_o});
        end
        checks++;
        if (pcNext_o !== 16'h0000 || rfWrData_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: pcNext %h rfWrData %h expected 0000 0000",
                     pcNext_o, rfWrData_o);
        end
    endtask

    task automatic test_directed();
        run_op("beq_taken", 16'h2005, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("bne_not_taken", 16'h27FF, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("bl_stall3", 16'h1FFE, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run_op("bl_immediate", 16'h0010, 16'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        run_op("illegal", 16'h4000, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_ge_lt_sweep();
        logic [15:0] w;
        for (int cond = 5; cond <= 6; cond++) begin
            for (int nv = 0; nv < 4; nv++) begin
                w = 16'h2000 | 16'(cond << 10) | 16'($urandom_range(0, 1023));
                run_op(cond == 5 ? "ge_sweep" : "lt_sweep", w, 16'($urandom),
                       1'($urandom), nv[1], 1'($urandom), nv[0], 0);
            end
        end
    endtask

    task automatic test_reset_mid_link();
        @(negedge clk_i);
        start_i = 1'b1; instWord_i = 16'h0040; pc_i = 16'h3000;
        rfWrGnt_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rfWrReq_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_req: rfWrReq %b expected 1", rfWrReq_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({busy_o, rfWrReq_o, done_o, pcWrEn_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_idle: busy/req/done/pcwr %b expected 0000",
                     {busy_o, rfWrReq_o, done_o, pcWrEn_o});
        end
        run_op("after_reset_bl", 16'h0003, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int i = 0; i < 40; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 7) != 0) w[15:14] = 2'b00;
            run_op("random", w, 16'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; instWord_i = '0; pc_i = '0;
        pswZ_i = 1'b0; pswN_i = 1'b0; pswC_i = 1'b0; pswV_i = 1'b0;
        rfWrGnt_i = 1'b0;
        test_reset();
        test_directed();
        test_ge_lt_sweep();
        test_reset_mid_link();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
